// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC/LEN/payload/CHK frames from a UART byte stream,
// buffers accepted payloads and replays them over a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 17400
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Cmd_Valid,
    input  logic       i_Cmd_Ready,
    output logic [7:0] o_Cmd_Byte,
    output logic       o_Cmd_Last,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun,
    output logic [7:0] o_Pkt_Count,
    output logic       o_Busy
);
    localparam int         IW    = $clog2(MAX_LEN + 1);
    localparam int         AW    = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int         TW    = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    pkt_q, pkt_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          cmd_valid_q, cmd_valid_d, cmd_last_q, cmd_last_d, busy_q, busy_d;
    logic          err_chk_q, err_chk_d, err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;
    logic          in_frame, tmo_hit, buf_we;
    logic [7:0]    buf_q [MAX_LEN];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        chk_d     = chk_q;
        pkt_d     = pkt_q;
        buf_we    = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        in_frame  = state_q inside {S_LEN, S_PAYLOAD, S_CHECK};
        // a byte arriving on the expiry cycle takes priority over the timeout
        tmo_hit   = in_frame && !i_Rx_DV && tmo_q == TW'(TIMEOUT_CLKS - 1);
        if (tmo_hit) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
        end else if (i_Rx_DV) begin
            case (state_q)
                S_IDLE: state_d = i_Rx_Byte == SYNC_BYTE ? S_LEN : S_IDLE;
                S_LEN: begin
                    if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = IW'(i_Rx_Byte);
                        chk_d   = i_Rx_Byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    buf_we  = 1'b1;
                    chk_d   = chk_q ^ i_Rx_Byte;
                    idx_d   = idx_q + 1'b1;
                    state_d = idx_d == len_q ? S_CHECK : S_PAYLOAD;
                end
                S_CHECK: begin
                    if (i_Rx_Byte != chk_q) begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        pkt_d   = pkt_q + 8'd1;
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: err_ovr_d = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
        if (state_q == S_DRAIN && cmd_valid_q && i_Cmd_Ready) begin
            idx_d   = idx_q + 1'b1;
            state_d = cmd_last_q ? S_IDLE : S_DRAIN;
        end
        tmo_d       = (in_frame && !i_Rx_DV && state_d == state_q) ? tmo_q + 1'b1 : '0;
        cmd_valid_d = state_d == S_DRAIN;
        cmd_byte_d  = cmd_valid_d ? buf_q[idx_d[AW-1:0]] : 8'd0;
        cmd_last_d  = cmd_valid_d && idx_d == len_q - 1'b1;
        busy_d      = state_d != S_IDLE;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            pkt_q       <= '0;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            pkt_q       <= pkt_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_last_q  <= cmd_last_d;
            busy_q      <= busy_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (buf_we) buf_q[idx_q[AW-1:0]] <= i_Rx_Byte;
    end

    assign o_Cmd_Valid   = cmd_valid_q;
    assign o_Cmd_Byte    = cmd_byte_q;
    assign o_Cmd_Last    = cmd_last_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Len     = err_len_q;
    assign o_Err_Timeout = err_tmo_q;
    assign o_Err_Overrun = err_ovr_q;
    assign o_Pkt_Count   = pkt_q;
    assign o_Busy        = busy_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frame scenarios plus randomized frames checked
// against a transaction-level model of accepted payloads and error counts.
module tb_uart_rx_frame_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 8;

    logic       clk = 1'b0, rst = 1'b1, dv = 1'b0, rdy = 1'b1, rand_rdy = 1'b0, mon_en = 1'b0;
    logic [7:0] rx_b = 8'd0;
    logic       valid, last, err_chk, err_len, err_tmo, err_ovr, busy;
    logic [7:0] cmd_byte, pkt;

    int checks = 0, errors = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;
    int e_chk = 0, e_len = 0, e_tmo = 0, e_pkt = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx_b),
        .o_Cmd_Valid(valid), .i_Cmd_Ready(rdy), .o_Cmd_Byte(cmd_byte), .o_Cmd_Last(last),
        .o_Err_Chk(err_chk), .o_Err_Len(err_len), .o_Err_Timeout(err_tmo),
        .o_Err_Overrun(err_ovr), .o_Pkt_Count(pkt), .o_Busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic rx(input logic [7:0] b);
        dv   = 1'b1;
        rx_b = b;
        tick();
        dv   = 1'b0;
    endtask

    task automatic rx_gap(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx(b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad length, 3 truncated (timeout)
    task automatic frame(input int kind, input int gmax);
        logic [7:0] fr[$];
        logic [7:0] len, chk, g;
        int n;
        if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom);
            rx_gap(g == 8'hA5 ? 8'h5A : g, $urandom_range(0, gmax));
        end
        if (kind == 2) begin
            len = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
            rx_gap(8'hA5, $urandom_range(0, gmax));
            rx_gap(len, $urandom_range(0, gmax));
            e_len++;
            tick();
            wait_idle();
            return;
        end
        len = 8'($urandom_range(1, MAX_LEN));
        chk = len;
        fr  = {8'hA5, len};
        for (int i = 0; i < int'(len); i++) begin
            fr.push_back(8'($urandom));
            chk ^= fr[i+2];
        end
        n = kind == 3 ? $urandom_range(1, int'(len) + 2) : int'(len) + 2;
        for (int i = 0; i < n; i++) rx_gap(fr[i], $urandom_range(0, gmax));
        if (kind == 3) begin
            repeat (TMO + 2) tick();
            e_tmo++;
        end else begin
            rx_gap(kind == 1 ? chk ^ 8'($urandom_range(1, 255)) : chk, $urandom_range(0, gmax));
            if (kind == 1) e_chk++;
            else begin
                e_pkt++;
                for (int i = 0; i < int'(len); i++) exp_q.push_back({i == int'(len) - 1, fr[i+2]});
            end
        end
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid && rdy) got_q.push_back({last, cmd_byte});
            if (err_chk) n_chk++;
            if (err_len) n_len++;
            if (err_tmo) n_tmo++;
            if (err_ovr) n_ovr++;
            if (32'(err_chk) + 32'(err_len) + 32'(err_tmo) + 32'(err_ovr) > 1) n_multi++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_pkt", 32'(pkt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_errs", {err_chk, err_len, err_tmo, err_ovr}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // good frame
        rx(8'hA5);
        check("good_busy", 32'(busy), 1);
        rx(8'h03); rx(8'h10); rx(8'h20); rx(8'h30);
        rx(8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30);
        check("good_v0", {valid, last, cmd_byte}, {2'b10, 8'h10});
        check("good_pkt", 32'(pkt), 1);
        tick();
        check("good_v1", {valid, last, cmd_byte}, {2'b10, 8'h20});
        tick();
        check("good_v2", {valid, last, cmd_byte}, {2'b11, 8'h30});
        tick();
        check("good_end", {valid, busy}, 0);
        check("good_errs", {err_chk, err_len, err_tmo, err_ovr}, 0);

        // bad checksum
        rx(8'hA5); rx(8'h02); rx(8'h11); rx(8'h22); rx(8'h00);
        check("chk_pulse", {err_chk, valid, busy}, 3'b100);
        check("chk_pkt", 32'(pkt), 1);
        tick();
        check("chk_clear", 32'(err_chk), 0);

        // length errors then a minimal good frame
        rx(8'hA5); rx(8'h00);
        check("len_zero", {err_len, busy}, 2'b10);
        rx(8'hA5); rx(8'h11);
        check("len_big", {err_len, busy}, 2'b10);
        rx(8'hA5); rx(8'h01); rx(8'h7F); rx(8'h7E);
        check("len_good", {valid, last, cmd_byte}, {2'b11, 8'h7F});
        tick();
        check("len_good_end", {valid, 8'(pkt)}, {1'b0, 8'd2});

        // timeout, ignored garbage, and a byte exactly at the expiry cycle
        rx(8'hA5); rx(8'h02); rx(8'h55);
        repeat (TMO - 1) tick();
        check("tmo_early", {err_tmo, busy}, 2'b01);
        tick();
        check("tmo_pulse", 32'(err_tmo), 1);
        tick();
        check("tmo_idle", {err_tmo, busy}, 0);
        rx(8'h44);
        check("garbage", 32'(busy), 0);
        rx(8'hA5);
        repeat (TMO - 1) tick();
        rx(8'h01);
        check("tmo_byte_wins", {err_tmo, busy}, 2'b01);
        rx(8'h7F); rx(8'h7E);
        check("tmo_after", {valid, last, cmd_byte}, {2'b11, 8'h7F});
        tick();
        check("tmo_pkt", 32'(pkt), 3);

        // back-pressure and overrun
        rdy = 1'b0;
        rx(8'hA5); rx(8'h02); rx(8'hAB); rx(8'hCD); rx(8'h02 ^ 8'hAB ^ 8'hCD);
        check("bp_first", {valid, last, cmd_byte}, {2'b10, 8'hAB});
        repeat (4) tick();
        check("bp_hold", {valid, last, cmd_byte}, {2'b10, 8'hAB});
        rx(8'hA5);
        check("ovr_pulse", {err_ovr, valid, cmd_byte}, {2'b11, 8'hAB});
        tick();
        check("ovr_clear", {err_ovr, cmd_byte}, {1'b0, 8'hAB});
        repeat (3) tick();
        rdy = 1'b1;
        tick();
        check("bp_second", {valid, last, cmd_byte}, {2'b11, 8'hCD});
        tick();
        check("bp_end", {valid, busy, 8'(pkt)}, {2'b00, 8'd4});

        // async reset mid-payload
        rx(8'hA5); rx(8'h03); rx(8'h01);
        #2 rst = 1'b1;
        #1;
        check("arst_now", {busy, valid, 8'(pkt)}, 0);
        tick();
        rst = 1'b0;
        rx(8'hA5); rx(8'h01); rx(8'h7F); rx(8'h7E);
        check("arst_frame", {valid, last, cmd_byte, 8'(pkt)}, {2'b11, 8'h7F, 8'd1});
        tick();

        // 255 more good frames wrap the packet counter
        e_pkt    = 1;
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 255; i++) frame(0, 1);
        check("pkt_wrap", 32'(pkt), 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            frame(r < 6 ? 0 : r == 6 ? 1 : r == 7 ? 2 : 3, TMO - 1);
        end
        repeat (3) tick();
        mon_en = 1'b0;

        check("n_bytes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("cmd_stream", 32'(got_q[i]), 32'(exp_q[i]));
        check("n_err_chk", n_chk, e_chk);
        check("n_err_len", n_len, e_len);
        check("n_err_tmo", n_tmo, e_tmo);
        check("n_err_ovr", n_ovr, 0);
        check("n_multi", n_multi, 0);
        check("pkt_final", 32'(pkt), e_pkt % 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
